// File: rtl/sap_pkg.sv
// Shared SAP system constants for the system bus and the RAM banks.
package sap_pkg;

    localparam int unsigned SYSTEM_XBAR_NMASTER       = 7;
    localparam logic [31:0] MEMORY_RAM0_START_ADDRESS = 32'h1902_0000;
    localparam logic [31:0] MEMORY_RAM0_SIZE          = 32'h0000_8000;
    localparam logic [31:0] MEMORY_RAM1_START_ADDRESS = 32'h1902_8000;
    localparam logic [31:0] MEMORY_RAM1_SIZE          = 32'h0000_8000;
    localparam int unsigned RAM_BANK_ADDR_W           = $clog2(MEMORY_RAM0_SIZE / 4);

    // Index width that stays at least one bit for a single requester.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sap_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus winner index, pointer moves past each winner.
module sap_rr_arbiter
    import sap_pkg::*;
#(
    parameter int unsigned N = SYSTEM_XBAR_NMASTER
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N-1:0]              i_req,
    output logic [N-1:0]              o_gnt,
    output logic [idx_width(N)-1:0]   o_idx,
    output logic                      o_any
);

    localparam int unsigned IDX_W = idx_width(N);

    logic [IDX_W-1:0] r_ptr;
    logic [N-1:0]     w_rot;
    logic [IDX_W-1:0] w_off;
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_idx;
    logic             w_any;

    // Rotate so that bit 0 is the master the pointer currently favours.
    assign w_rot = N'({i_req, i_req} >> r_ptr);
    assign w_any = |i_req;

    always_comb begin
        w_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDX_W'(i);
            end
        end
    end

    assign w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_idx = (w_sum >= (IDX_W + 1)'(N)) ? IDX_W'(w_sum - (IDX_W + 1)'(N))
                                               : w_sum[IDX_W-1:0];

    assign o_gnt = w_any ? (N'(1) << w_idx) : '0;
    assign o_idx = w_idx;
    assign o_any = w_any;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= (w_idx == IDX_W'(N - 1)) ? '0 : w_idx + 1'b1;
        end
    end

endmodule

// File: rtl/sap_ram_bank_arbiter.sv
// Shares one SAP RAM bank between all system-bus masters with round-robin
// arbitration, a range check and a one-cycle response return path.
module sap_ram_bank_arbiter
    import sap_pkg::*;
#(
    parameter int unsigned NMASTER    = SYSTEM_XBAR_NMASTER,
    parameter int unsigned DATA_W     = 32,
    parameter logic [31:0] BANK_START = MEMORY_RAM0_START_ADDRESS,
    parameter logic [31:0] BANK_SIZE  = MEMORY_RAM0_SIZE,
    parameter int unsigned RAM_ADDR_W = RAM_BANK_ADDR_W
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NMASTER-1:0]          m_req_i,
    input  logic [NMASTER-1:0]          m_we_i,
    input  logic [NMASTER*4-1:0]        m_be_i,
    input  logic [NMASTER*32-1:0]       m_addr_i,
    input  logic [NMASTER*DATA_W-1:0]   m_wdata_i,
    output logic [NMASTER-1:0]          m_gnt_o,
    output logic [NMASTER-1:0]          m_rvalid_o,
    output logic [NMASTER-1:0]          m_err_o,
    output logic [DATA_W-1:0]           m_rdata_o,
    output logic                        ram_req_o,
    output logic                        ram_we_o,
    output logic [3:0]                  ram_be_o,
    output logic [RAM_ADDR_W-1:0]       ram_addr_o,
    output logic [DATA_W-1:0]           ram_wdata_o,
    input  logic [DATA_W-1:0]           ram_rdata_i
);

    localparam int unsigned IDX_W    = idx_width(NMASTER);
    localparam logic [31:0] BANK_END = BANK_START + BANK_SIZE;

    logic [IDX_W-1:0]      w_idx;
    logic                  w_any;
    logic                  w_we;
    logic [3:0]            w_be;
    logic [31:0]           w_addr;
    logic [DATA_W-1:0]     w_wdata;
    logic                  w_in_range;
    logic [RAM_ADDR_W-1:0] w_word;

    logic                  r_resp_vld_p1;
    logic [IDX_W-1:0]      r_resp_idx_p1;
    logic                  r_resp_err_p1;

    sap_rr_arbiter #(
        .N (NMASTER)
    ) u_arb (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_req (m_req_i),
        .o_gnt (m_gnt_o),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // p0: winner's request fields, range check and SRAM drive
    always_comb begin
        w_we    = 1'b0;
        w_be    = '0;
        w_addr  = '0;
        w_wdata = '0;
        for (int k = 0; k < NMASTER; k++) begin
            if (w_idx == IDX_W'(k)) begin
                w_we    = m_we_i[k];
                w_be    = m_be_i[k*4 +: 4];
                w_addr  = m_addr_i[k*32 +: 32];
                w_wdata = m_wdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_in_range = (w_addr >= BANK_START) && (w_addr < BANK_END);
    assign w_word     = RAM_ADDR_W'((w_addr - BANK_START) >> 2);

    assign ram_req_o   = w_any && w_in_range;
    assign ram_we_o    = w_any && w_we;
    assign ram_be_o    = w_any ? w_be    : '0;
    assign ram_addr_o  = w_any ? w_word  : '0;
    assign ram_wdata_o = w_any ? w_wdata : '0;

    // p1: response routed back to the master granted one cycle earlier
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_resp_vld_p1 <= 1'b0;
            r_resp_idx_p1 <= '0;
            r_resp_err_p1 <= 1'b0;
        end else begin
            r_resp_vld_p1 <= w_any;
            if (w_any) begin
                r_resp_idx_p1 <= w_idx;
                r_resp_err_p1 <= !w_in_range;
            end
        end
    end

    assign m_rvalid_o = r_resp_vld_p1 ? (NMASTER'(1) << r_resp_idx_p1) : '0;
    assign m_err_o    = (r_resp_vld_p1 && r_resp_err_p1) ? (NMASTER'(1) << r_resp_idx_p1) : '0;
    assign m_rdata_o  = (r_resp_vld_p1 && !r_resp_err_p1) ? ram_rdata_i : '0;

endmodule

// File: tb/tb_sap_ram_bank_arbiter.sv
// Bench for sap_ram_bank_arbiter: directed scenarios plus randomized traffic
// against a distance-based round-robin reference model.
module tb_sap_ram_bank_arbiter;

    localparam int NM = 7;
    localparam logic [31:0] BSTART = 32'h1902_0000;
    localparam logic [31:0] BEND   = 32'h1902_8000;

    logic              clk;
    logic              rst;
    logic [NM-1:0]     req, we;
    logic [NM*4-1:0]   be;
    logic [NM*32-1:0]  addr, wdata;
    logic [NM-1:0]     gnt, rvalid, err;
    logic [31:0]       rdata;
    logic              ram_req, ram_we;
    logic [3:0]        ram_be;
    logic [12:0]       ram_addr;
    logic [31:0]       ram_wdata, ram_rdata;

    int checks = 0;
    int errors = 0;

    logic [NM-1:0] p_req;
    logic          p_we    [NM];
    logic [3:0]    p_be    [NM];
    logic [31:0]   p_addr  [NM];
    logic [31:0]   p_wdata [NM];

    int m_last;
    int mr_vld, mr_idx, mr_err;

    sap_ram_bank_arbiter dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .m_req_i     (req),
        .m_we_i      (we),
        .m_be_i      (be),
        .m_addr_i    (addr),
        .m_wdata_i   (wdata),
        .m_gnt_o     (gnt),
        .m_rvalid_o  (rvalid),
        .m_err_o     (err),
        .m_rdata_o   (rdata),
        .ram_req_o   (ram_req),
        .ram_we_o    (ram_we),
        .ram_be_o    (ram_be),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply();
        for (int k = 0; k < NM; k++) begin
            req[k]            = p_req[k];
            we[k]             = p_we[k];
            be[k*4 +: 4]      = p_be[k];
            addr[k*32 +: 32]  = p_addr[k];
            wdata[k*32 +: 32] = p_wdata[k];
        end
        #1;
    endtask

    task automatic clear_masters();
        for (int k = 0; k < NM; k++) begin
            p_req[k] = 1'b0; p_we[k] = 1'b0; p_be[k] = 4'h0;
            p_addr[k] = 32'h0; p_wdata[k] = 32'h0;
        end
    endtask

    task automatic set_master(input int k, input logic w, input logic [3:0] b,
                              input logic [31:0] a, input logic [31:0] d);
        p_req[k] = 1'b1; p_we[k] = w; p_be[k] = b; p_addr[k] = a; p_wdata[k] = d;
    endtask

    task automatic do_reset();
        clear_masters();
        apply();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_last = NM - 1;
        mr_vld = 0; mr_idx = 0; mr_err = 0;
    endtask

    // Winner is the requester closest after the last granted master.
    function automatic int exp_winner(input logic [NM-1:0] mask, input int last);
        int best, bestd, d;
        best = -1; bestd = NM;
        for (int k = 0; k < NM; k++) begin
            d = (k - last - 1 + 2 * NM) % NM;
            if (mask[k] && d < bestd) begin best = k; bestd = d; end
        end
        return best;
    endfunction

    task automatic test_reset();
        clear_masters();
        apply();
        rst = 1'b1;
        ram_rdata = 32'hFFFF_FFFF;
        tick();
        tick();
        checks++; if (rvalid !== '0) begin errors++; $display("FAIL rst_rvalid got %b exp 0", rvalid); end
        checks++; if (err !== '0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", rdata); end
        checks++; if ({gnt, ram_req, ram_we, ram_be, ram_addr, ram_wdata} !== '0) begin
            errors++; $display("FAIL rst_outputs gnt %b req %b addr %h exp all 0", gnt, ram_req, ram_addr);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        set_master(1, 1'b0, 4'hF, 32'h1902_0010, 32'h0);
        apply();
        checks++; if (gnt !== 7'b0000010) begin errors++; $display("FAIL sr_gnt got %b exp 0000010", gnt); end
        checks++; if (ram_req !== 1'b1 || ram_addr !== 13'd4 || ram_we !== 1'b0) begin
            errors++; $display("FAIL sr_ram got req %b addr %h we %b exp 1 004 0", ram_req, ram_addr, ram_we);
        end
        tick();
        clear_masters();
        ram_rdata = 32'hCAFE_0001;
        apply();
        checks++; if (rvalid !== 7'b0000010 || err !== '0) begin
            errors++; $display("FAIL sr_rvalid got %b err %b exp 0000010 0", rvalid, err);
        end
        checks++; if (rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL sr_rdata got %h exp cafe0001", rdata); end
        tick();
        checks++; if (rvalid !== '0 || rdata !== 32'h0) begin
            errors++; $display("FAIL sr_idle got rvalid %b rdata %h exp 0 0", rvalid, rdata);
        end
    endtask

    task automatic test_contention();
        logic [31:0] rv;
        do_reset();
        for (int k = 0; k < NM; k++) set_master(k, 1'b0, 4'hF, BSTART + 32'(k * 64), 32'h0);
        for (int i = 0; i < 8; i++) begin
            rv = $urandom;
            ram_rdata = rv;
            apply();
            checks++; if (gnt !== (7'b1 << (i % NM))) begin
                errors++; $display("FAIL cont_gnt cycle %0d got %b exp %b", i, gnt, 7'b1 << (i % NM));
            end
            checks++; if (rvalid !== ((i == 0) ? 7'b0 : (7'b1 << ((i - 1) % NM)))) begin
                errors++; $display("FAIL cont_rvalid cycle %0d got %b", i, rvalid);
            end
            checks++; if (rdata !== ((i == 0) ? 32'h0 : rv)) begin
                errors++; $display("FAIL cont_rdata cycle %0d got %h exp %h", i, rdata, (i == 0) ? 32'h0 : rv);
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        do_reset();
        set_master(6, 1'b0, 4'hF, BSTART, 32'h0);
        apply();
        checks++; if (gnt !== 7'b1000000) begin errors++; $display("FAIL wrap_g6 got %b exp 1000000", gnt); end
        tick();
        clear_masters();
        set_master(2, 1'b0, 4'hF, BSTART + 32'h8, 32'h0);
        set_master(5, 1'b0, 4'hF, BSTART + 32'h14, 32'h0);
        apply();
        checks++; if (gnt !== 7'b0000100) begin errors++; $display("FAIL wrap_g2 got %b exp 0000100", gnt); end
        tick();
        p_req[2] = 1'b0;
        apply();
        checks++; if (gnt !== 7'b0100000) begin errors++; $display("FAIL wrap_g5 got %b exp 0100000", gnt); end
        checks++; if (ram_addr !== 13'd5) begin errors++; $display("FAIL wrap_addr got %h exp 005", ram_addr); end
        tick();
    endtask

    task automatic test_out_of_range();
        do_reset();
        set_master(3, 1'b1, 4'hF, 32'h1902_8000, 32'h1234_5678);
        apply();
        checks++; if (gnt !== 7'b0001000 || ram_req !== 1'b0) begin
            errors++; $display("FAIL oor_grant got gnt %b req %b exp 0001000 0", gnt, ram_req);
        end
        tick();
        clear_masters();
        ram_rdata = 32'hDEAD_BEEF;
        apply();
        checks++; if (rvalid !== 7'b0001000 || err !== 7'b0001000) begin
            errors++; $display("FAIL oor_resp got rvalid %b err %b exp 0001000 0001000", rvalid, err);
        end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL oor_rdata got %h exp 0", rdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_master(0, 1'b1, 4'b0011, 32'h1902_7FFC, 32'hAABB_CCDD);
        apply();
        checks++; if (gnt !== 7'b1 || ram_req !== 1'b1 || ram_we !== 1'b1 || ram_be !== 4'b0011) begin
            errors++; $display("FAIL b2b_wr got gnt %b req %b we %b be %b", gnt, ram_req, ram_we, ram_be);
        end
        checks++; if (ram_addr !== 13'h1FFF || ram_wdata !== 32'hAABB_CCDD) begin
            errors++; $display("FAIL b2b_wr_addr got %h data %h exp 1fff aabbccdd", ram_addr, ram_wdata);
        end
        tick();
        set_master(0, 1'b0, 4'hF, 32'h1902_7FFC, 32'h0);
        apply();
        checks++; if (gnt !== 7'b1 || ram_we !== 1'b0 || ram_addr !== 13'h1FFF) begin
            errors++; $display("FAIL b2b_rd got gnt %b we %b addr %h exp 1 0 1fff", gnt, ram_we, ram_addr);
        end
        checks++; if (rvalid !== 7'b1) begin errors++; $display("FAIL b2b_wr_rvalid got %b exp 0000001", rvalid); end
        tick();
        clear_masters();
        ram_rdata = 32'h5555_AAAA;
        apply();
        checks++; if (rvalid !== 7'b1 || rdata !== 32'h5555_AAAA) begin
            errors++; $display("FAIL b2b_rd_resp got %b %h exp 0000001 5555aaaa", rvalid, rdata);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        set_master(4, 1'b0, 4'hF, BSTART + 32'h40, 32'h0);
        apply();
        checks++; if (gnt !== 7'b0010000) begin errors++; $display("FAIL rmf_g4 got %b exp 0010000", gnt); end
        tick();
        clear_masters();
        apply();
        rst = 1'b1;
        tick();
        checks++; if (rvalid !== '0) begin errors++; $display("FAIL rmf_norvalid got %b exp 0", rvalid); end
        rst = 1'b0;
        set_master(6, 1'b0, 4'hF, BSTART, 32'h0);
        apply();
        checks++; if (gnt !== 7'b1000000) begin errors++; $display("FAIL rmf_g6 got %b exp 1000000", gnt); end
        tick();
        clear_masters();
        set_master(4, 1'b0, 4'hF, BSTART, 32'h0);
        apply();
        tick();
        clear_masters();
        apply();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_master(3, 1'b0, 4'hF, BSTART, 32'h0);
        set_master(6, 1'b0, 4'hF, BSTART, 32'h0);
        apply();
        checks++; if (gnt !== 7'b0001000) begin errors++; $display("FAIL rmf_ptr0 got %b exp 0001000", gnt); end
        tick();
    endtask

    task automatic test_random();
        int w, sel;
        logic inr;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < NM; k++) begin
                if (!p_req[k] && ($urandom_range(0, 1) == 1)) begin
                    sel = $urandom_range(0, 9);
                    if (sel < 8) p_addr[k] = BSTART + ($urandom_range(0, 8191) << 2) + $urandom_range(0, 3);
                    else if (sel == 8) p_addr[k] = BEND + $urandom_range(0, 255);
                    else p_addr[k] = BSTART - 32'(1 + $urandom_range(0, 15));
                    p_req[k] = 1'b1; p_we[k] = 1'($urandom_range(0, 1));
                    p_be[k] = 4'($urandom); p_wdata[k] = $urandom;
                end
            end
            ram_rdata = $urandom;
            apply();
            w = exp_winner(p_req, m_last);
            if (w < 0) begin
                checks++; if ({gnt, ram_req, ram_we, ram_be, ram_addr, ram_wdata} !== '0) begin
                    errors++; $display("FAIL rnd_idle cycle %0d gnt %b req %b", cyc, gnt, ram_req);
                end
            end else begin
                inr = (p_addr[w] >= BSTART) && (p_addr[w] < BEND);
                checks++; if (gnt !== (7'b1 << w)) begin
                    errors++; $display("FAIL rnd_gnt cycle %0d got %b exp %b", cyc, gnt, 7'b1 << w);
                end
                checks++; if (ram_req !== inr || ram_we !== p_we[w] || ram_be !== p_be[w]) begin
                    errors++; $display("FAIL rnd_ctl cycle %0d got req %b we %b be %b exp %b %b %b",
                                       cyc, ram_req, ram_we, ram_be, inr, p_we[w], p_be[w]);
                end
                checks++; if (ram_addr !== 13'((p_addr[w] - BSTART) / 4) || ram_wdata !== p_wdata[w]) begin
                    errors++; $display("FAIL rnd_addr cycle %0d got %h %h exp %h %h", cyc, ram_addr, ram_wdata,
                                       13'((p_addr[w] - BSTART) / 4), p_wdata[w]);
                end
            end
            checks++; if (rvalid !== (mr_vld ? (7'b1 << mr_idx) : 7'b0) ||
                          err !== ((mr_vld && mr_err) ? (7'b1 << mr_idx) : 7'b0) ||
                          rdata !== ((mr_vld && !mr_err) ? ram_rdata : 32'h0)) begin
                errors++; $display("FAIL rnd_resp cycle %0d got rvalid %b err %b rdata %h exp idx %0d vld %0d err %0d",
                                   cyc, rvalid, err, rdata, mr_idx, mr_vld, mr_err);
            end
            mr_vld = (w >= 0);
            if (w >= 0) begin
                mr_idx = w;
                mr_err = inr ? 0 : 1;
                m_last = w;
                p_req[w] = 1'b0;
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        ram_rdata = 32'h0;
        clear_masters();
        apply();
        test_reset();
        test_single_read();
        test_contention();
        test_wrap();
        test_out_of_range();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
